execute_stage: RTL
==================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter N, default 64, datapath width.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present this cycle.
- icode  in  4  instruction code from fetch.
- ifun  in  4  function code from fetch.
- valA  in  N  register operand A from decode_writeback.
- valB  in  N  register operand B from decode_writeback.
- valC  in  N  constant from fetch.
- valE  out  N  ALU result, combinational.
- Cnd  out  1  branch/move condition, combinational.
- cc  out  3  registered flags {ZF,SF,OF}.
- stat  out  2  registered status: 0 AOK, 1 HLT, 2 INS.

Function
REQ-003 SHALL compute valE combinationally:
- cmovXX: valA+0.
- irmovq: valC+0.
- rmmovq, mrmovq: valB+valC.
- OPq: valB op valA, where ifun 0 = add, 1 = sub (valB-valA), 2 = and, 3 = xor.
- call, pushq: valB-8.
- ret, popq: valB+8.
- halt, nop, jXX, invalid: 0.
REQ-004 SHALL do all arithmetic modulo 2^N and ignore carry-out.
REQ-005 SHALL compute OF as follows:
- add: OF=1 iff both operands have the same sign and the result sign differs from it.
- sub: OF=1 iff the valA and valB signs differ and the result sign differs from the valB sign.
- and, xor: OF=0.
REQ-006 SHALL set ZF=1 iff the OPq result is 0, and SF equal to the result MSB.
REQ-007 SHALL update cc at posedge clk only when in_valid=1, stat=AOK, icode=6 and ifun<=3; otherwise cc SHALL hold its value.
REQ-008 SHALL derive Cnd from the current registered cc (the value before any same-edge update) for icode 2 and 7:
- ifun 0: 1.
- ifun 1 (le): (SF^OF)|ZF.
- ifun 2 (l): SF^OF.
- ifun 3 (e): ZF.
- ifun 4 (ne): ~ZF.
- ifun 5 (ge): ~(SF^OF).
- ifun 6 (g): ~(SF^OF)&~ZF.
REQ-009 SHALL drive Cnd=0 for any other icode, for ifun>6, when in_valid=0, or when stat!=AOK.
REQ-010 SHALL treat an instruction as invalid when any of the following hold: icode>0xB; icode=6 with ifun>3; icode 2 or 7 with ifun>6; icode not 2, 6 or 7 with ifun!=0.
REQ-011 SHALL implement stat as a three-state machine (AOK, HLT, INS):
- AOK to HLT on in_valid with icode=0.
- AOK to INS on in_valid with an invalid instruction.
- HLT and INS are absorbing until reset.
REQ-012 SHALL NOT update cc in the cycle that moves stat out of AOK.
REQ-013 SHALL ignore inputs when in_valid=0, leaving state unchanged.

Reset
REQ-014 SHALL, on rst_n low and asynchronously, force cc=3'b100 (ZF=1, SF=0, OF=0) and stat=AOK.
REQ-015 SHALL make valE and Cnd depend only on inputs and the reset-state registers during reset.
REQ-016 SHALL restore the reset values if reset is asserted mid-operation in any state, including HLT and INS.

Configuration
REQ-017 SHALL support macro EXEC_IADDQ_EN:
- Defined: icode 0xC with ifun 0 is valid, valE=valB+valC, and cc is updated under the REQ-007 conditions with add flag rules.
- Undefined: icode 0xC is invalid and drives stat to INS.

Structure
REQ-018 SHALL place icode constants, OPq function codes, condition function codes, stat encodings and the cc bit indices in a shared package y86_pkg.
REQ-019 SHALL instantiate one combinational sub-module alu (inputs aluA, aluB, alufun; outputs result, zf, sf, of); CC register, condition logic and stat FSM reside in execute_stage.

Verification
REQ-020 Reset: assert rst_n=0 mid-cycle -> cc=3'b100 and stat=0 immediately; Cnd=1 for icode=7, ifun=3.
REQ-021 OPq sub: valB=5, valA=7 -> valE=-2, and after posedge cc={0,1,0}; jl (7/2) in the next cycle -> Cnd=1.
REQ-022 OPq add overflow: valA=valB=0x4000_0000_0000_0000 -> valE=0x8000_0000_0000_0000, and after the edge cc={0,1,1}; jge -> Cnd=1, jl -> Cnd=0.
REQ-023 Non-OP instructions: pushq with valB=100 -> valE=92; rmmovq with valB=500, valC=8 -> valE=508; cc unchanged across both edges.
REQ-024 Halt: in_valid=1, icode=0 -> stat=1 after the edge; a subsequent OPq leaves cc frozen and Cnd=0; rst_n pulse -> stat=0.
REQ-025 Invalid instruction: icode=0xC with valB=3, valC=4 -> with EXEC_IADDQ_EN, valE=7 and stat stays 0; without it, stat=2 after the edge and cc is unchanged.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg -- shared encodings for the Y86-64 execute stage.
//   icode constants, OPq function codes (the low two bits drive the ALU
//   directly), branch/move condition codes, stat encodings, cc bit indices,
//   and a helper that evaluates a condition code against the flags.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_IADDQ  = 4'hC;

    // OPq function codes (ifun[1:0] for OPq; ifun[3:2] must be zero)
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    // Condition function codes for cmovXX / jXX
    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;

    // Status encodings
    typedef enum logic [1:0] {
        S_AOK = 2'd0,
        S_HLT = 2'd1,
        S_INS = 2'd2
    } stat_t;

    // cc = {ZF, SF, OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;
    localparam logic [2:0] CC_RESET = 3'b100;

    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
        logic zf, sf, of;
        zf = cc[CC_ZF];
        sf = cc[CC_SF];
        of = cc[CC_OF];
        case (fn)
            C_YES:   cond_eval = 1'b1;
            C_LE:    cond_eval = (sf ^ of) | zf;
            C_L:     cond_eval = sf ^ of;
            C_E:     cond_eval = zf;
            C_NE:    cond_eval = ~zf;
            C_GE:    cond_eval = ~(sf ^ of);
            C_G:     cond_eval = ~(sf ^ of) & ~zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// alu -- combinational N-bit ALU for the execute stage.
//   aluA, aluB : operands; result = aluB op aluA (modulo 2^N)
//   alufun     : ALU_ADD / ALU_SUB / ALU_AND / ALU_XOR
//   zf, sf, of : flags of the result (of is 0 for logical ops)
module alu
    import y86_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] aluA,
    input  logic [N-1:0] aluB,
    input  logic [1:0]   alufun,
    output logic [N-1:0] result,
    output logic         zf,
    output logic         sf,
    output logic         of
);

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (alufun)
            ALU_ADD: begin
                result = aluB + aluA;
                of     = (aluA[N-1] == aluB[N-1]) && (result[N-1] != aluB[N-1]);
            end
            ALU_SUB: begin
                result = aluB - aluA;
                of     = (aluA[N-1] != aluB[N-1]) && (result[N-1] != aluB[N-1]);
            end
            ALU_AND: result = aluB & aluA;
            default: result = aluB ^ aluA;
        endcase
    end

    assign zf = (result == '0);
    assign sf = result[N-1];

endmodule

// File: rtl/execute_stage.sv
// execute_stage -- Y86-64 execute stage: ALU operand selection, condition
// code register, branch/move condition and the AOK/HLT/INS status machine.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid         : instruction present this cycle
//   icode, ifun      : instruction / function code from fetch
//   valA, valB, valC : operands from decode and fetch
//   valE, Cnd        : combinational ALU result and condition
//   cc, stat         : registered {ZF,SF,OF} flags and status
// Optional feature: define EXEC_IADDQ_EN to accept iaddq (icode 0xC, ifun 0).
module execute_stage
    import y86_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [N-1:0] valA,
    input  logic [N-1:0] valB,
    input  logic [N-1:0] valC,
    output logic [N-1:0] valE,
    output logic         Cnd,
    output logic [2:0]   cc,
    output logic [1:0]   stat
);

    localparam logic [N-1:0] EIGHT = N'(8);

    stat_t        stat_q, stat_d;
    logic [2:0]   cc_q;
    logic         invalid, use_alu, sets_cc, cc_we;
    logic [N-1:0] alu_a, alu_b, alu_res;
    logic [1:0]   alu_fun;
    logic         zf, sf, of;

    always_comb begin
        invalid = 1'b0;
        case (icode)
            I_CMOVXX, I_JXX: invalid = (ifun > C_G);
            I_OPQ:           invalid = (ifun > {2'b00, ALU_XOR});
`ifdef EXEC_IADDQ_EN
            I_IADDQ:         invalid = (ifun != 4'd0);
`else
            I_IADDQ:         invalid = 1'b1;
`endif
            default:         invalid = (icode > I_POPQ) || (ifun != 4'd0);
        endcase
    end

    // Operand routing; instructions that produce no value leave use_alu low
    // so valE reads as zero.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_fun = ALU_ADD;
        use_alu = 1'b0;
        sets_cc = 1'b0;
        if (!invalid) begin
            case (icode)
                I_CMOVXX:         begin alu_a = valA; use_alu = 1'b1; end
                I_IRMOVQ:         begin alu_a = valC; use_alu = 1'b1; end
                I_RMMOVQ, I_MRMOVQ: begin alu_a = valC; alu_b = valB; use_alu = 1'b1; end
                I_OPQ: begin
                    alu_a   = valA;
                    alu_b   = valB;
                    alu_fun = ifun[1:0];
                    use_alu = 1'b1;
                    sets_cc = 1'b1;
                end
                I_CALL, I_PUSHQ: begin
                    alu_a = EIGHT; alu_b = valB; alu_fun = ALU_SUB; use_alu = 1'b1;
                end
                I_RET, I_POPQ:    begin alu_a = EIGHT; alu_b = valB; use_alu = 1'b1; end
`ifdef EXEC_IADDQ_EN
                I_IADDQ: begin
                    alu_a = valC; alu_b = valB; use_alu = 1'b1; sets_cc = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    alu #(.N(N)) u_alu (
        .aluA   (alu_a),
        .aluB   (alu_b),
        .alufun (alu_fun),
        .result (alu_res),
        .zf     (zf),
        .sf     (sf),
        .of     (of)
    );

    assign valE = use_alu ? alu_res : '0;

    // Condition reads the flags as registered before this edge.
    assign Cnd = in_valid && (stat_q == S_AOK) && !invalid &&
                 ((icode == I_CMOVXX) || (icode == I_JXX)) && cond_eval(ifun, cc_q);

    always_comb begin
        stat_d = stat_q;
        if (stat_q == S_AOK && in_valid) begin
            if (invalid)              stat_d = S_INS;
            else if (icode == I_HALT) stat_d = S_HLT;
        end
    end

    assign cc_we = in_valid && (stat_q == S_AOK) && (stat_d == S_AOK) && sets_cc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= S_AOK;
            cc_q   <= CC_RESET;
        end else begin
            stat_q <= stat_d;
            if (cc_we) cc_q <= {zf, sf, of};
        end
    end

    assign cc   = cc_q;
    assign stat = stat_q;

endmodule
